md_unit: RTL

//   Multiply/divide responder for the E stage. Executes the mult/multu/div/divu

---
 rtl/md_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multiply/divide responder for the E stage.
// Owns HI/LO, runs mult/multu/div/divu with a fixed busy latency per operation
// class, and services mthi/mtlo writes while idle. The result is computed
// combinationally at launch and held in pending registers until the last busy
// cycle. This models the latency the hazard unit expects without building an
// iterative datapath.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // 64-bit product, with optional two's-complement sign extension of both operands.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {{32{sgn & x[31]}}, x};
        ye = {{32{sgn & y[31]}}, y};
        return xe * ye;
    endfunction

    // {remainder, quotient}. Signed mode works on magnitudes, then truncates toward zero.
    // The remainder takes the sign of the dividend. 0x80000000 / -1 falls out as
    // quotient 0x80000000 and remainder 0, because the magnitude of 0x80000000 is
    // itself. A zero divisor is replaced by 1 here, so no division by zero is ever
    // evaluated; the caller suppresses the commit in that case.
    function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic        neg_x;
        logic        neg_y;
        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] q;
        logic [31:0] r;
        neg_x = sgn & x[31];
        neg_y = sgn & y[31];
        mx    = neg_x ? (32'h0000_0000 - x) : x;
        my    = neg_y ? (32'h0000_0000 - y) : y;
        if (my == 32'h0000_0000) begin
            my = 32'h0000_0001;
        end else begin
            my = my;
        end
        q = mx / my;
        r = mx % my;
        if (neg_x ^ neg_y) begin
            q = 32'h0000_0000 - q;
        end else begin
            q = q;
        end
        if (neg_x) begin
            r = 32'h0000_0000 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [31:0]     pend_hi_q;
    logic [31:0]     pend_hi_d;
    logic [31:0]     pend_lo_q;
    logic [31:0]     pend_lo_d;
    logic            pend_wr_q;
    logic            pend_wr_d;
    logic [31:0]     hi_q;
    logic [31:0]     hi_d;
    logic [31:0]     lo_q;
    logic [31:0]     lo_d;

    logic            busy_s;
    logic            load_s;
    logic            commit_s;
    logic            mtx_ok_s;
    logic [63:0]     res_s;

    // State register: IDLE/BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: launch on start while idle, return to idle on the final busy cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: busy flag, launch strobe, commit strobe and the mthi/mtlo window.
    always_comb begin
        busy_s   = 1'b0;
        load_s   = 1'b0;
        commit_s = 1'b0;
        mtx_ok_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_s   = start;
                mtx_ok_s = ~start;
            end
            ST_BUSY: begin
                busy_s   = 1'b1;
                commit_s = (cnt_q == CW'(1));
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Operation result for the current request; only captured on launch.
    always_comb begin
        res_s = 64'h0;
        if (mdop[1]) begin
            res_s = div64(a, b, ~mdop[0]);
        end else begin
            res_s = mul64(a, b, ~mdop[0]);
        end
    end

    // Next values for the counter and the pending result registers.
    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (load_s) begin
            cnt_d     = mdop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend_hi_d = res_s[63:32];
            pend_lo_d = res_s[31:0];
            pend_wr_d = ~(mdop[1] & (b == 32'h0000_0000));
        end else if (busy_s) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and pending result storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pend_hi_q <= 32'h0000_0000;
            pend_lo_q <= 32'h0000_0000;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // HI/LO next value: commit the pending result, or take an idle mthi/mtlo write.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit_s && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end else if (mtx_ok_s) begin
            hi_d = mthi ? wdata : hi_q;
            lo_d = mtlo ? wdata : lo_q;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'h0000_0000;
            lo_q <= 32'h0000_0000;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign busy = busy_s;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
